// File: rtl/emc_trig_window_seq.sv
// emc_trig_window_seq: qualifies L0/L1/L2 trigger pulses against per-event
// latency windows in the 40 MHz TTC domain, drives the FEE trigger pulses,
// the trigger-side busy, and the event / drop / error counters.
module emc_trig_window_seq #(
    parameter logic [31:0] L1_TW_INIT = 32'h012C_0078,
    parameter logic [31:0] L2_TW_INIT = 32'h4E20_00C8
) (
    input  logic        ttc_clk40,
    input  logic        reset_n,
    input  logic [31:0] l1_tw,
    input  logic [31:0] l2_tw,
    input  logic        tw_load,
    input  logic        l0_trig,
    input  logic        l1_in,
    input  logic        l2a_in,
    input  logic        l2r_in,
    input  logic        busy_in,
    input  logic        cnt_clr,
    output logic        l1_out,
    output logic        l2a_out,
    output logic        l2r_out,
    output logic        trig_busy,
    output logic        l1_early,
    output logic        l1_miss,
    output logic        l2_miss,
    output logic [23:0] evt_cnt,
    output logic [15:0] l0_drop_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_L1WAIT = 2'd1,
        ST_L2WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] win_q, win_d;          // window of the sequence in flight {max, min}
    logic [31:0] cfg_l1_q, cfg_l1_d;    // active L1 window configuration
    logic [31:0] cfg_l2_q, cfg_l2_d;    // active L2 window configuration
    logic        l1_out_q, l1_out_d;
    logic        l2a_out_q, l2a_out_d;
    logic        l2r_out_q, l2r_out_d;
    logic        trig_busy_q, trig_busy_d;
    logic        l1_early_q, l1_early_d;
    logic        l1_miss_q, l1_miss_d;
    logic        l2_miss_q, l2_miss_d;
    logic [23:0] evt_cnt_q, evt_cnt_d;
    logic [15:0] l0_drop_cnt_q, l0_drop_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic [15:0] win_min_s;
    logic [15:0] win_max_s;
    logic        in_win_s;
    logic        evt_inc_s;
    logic        drop_inc_s;
    logic        err_inc_s;

    assign win_min_s = win_q[15:0];
    assign win_max_s = win_q[31:16];
    // Both window edges are inclusive; min > max can never match.
    assign in_win_s  = (cnt_q >= win_min_s) && (cnt_q <= win_max_s);

    // Sequencer next state, window counter, qualified pulses and counter updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        cfg_l1_d    = cfg_l1_q;
        cfg_l2_d    = cfg_l2_q;
        l1_out_d    = 1'b0;
        l2a_out_d   = 1'b0;
        l2r_out_d   = 1'b0;
        l1_early_d  = 1'b0;
        l1_miss_d   = 1'b0;
        l2_miss_d   = 1'b0;
        evt_inc_s   = 1'b0;
        drop_inc_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                // Capture uses the configuration active before any same-cycle load.
                if (l0_trig) begin
                    if (busy_in) begin
                        drop_inc_s = 1'b1;
                    end else begin
                        win_d   = cfg_l1_q;
                        cnt_d   = 16'd1;
                        state_d = ST_L1WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
                if (tw_load) begin
                    cfg_l1_d = l1_tw;
                    cfg_l2_d = l2_tw;
                end else begin
                    cfg_l1_d = cfg_l1_q;
                    cfg_l2_d = cfg_l2_q;
                end
            end
            ST_L1WAIT: begin
                drop_inc_s = l0_trig;
                cnt_d      = cnt_q + 16'd1;
                if (l1_in && in_win_s) begin
                    l1_out_d = 1'b1;
                    win_d    = cfg_l2_q;
                    cnt_d    = 16'd1;
                    state_d  = ST_L2WAIT;
                end else if (l1_in && (cnt_q < win_min_s)) begin
                    l1_early_d = 1'b1;
                end else if (cnt_q >= win_max_s) begin
                    // ">=" also closes an early-at-max corner one cycle later.
                    l1_miss_d = 1'b1;
                    cnt_d     = 16'd0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_L1WAIT;
                end
            end
            ST_L2WAIT: begin
                drop_inc_s = l0_trig;
                cnt_d      = cnt_q + 16'd1;
                if ((l2a_in || l2r_in) && in_win_s) begin
                    // Simultaneous accept and reject resolve to reject.
                    if (l2r_in) begin
                        l2r_out_d = 1'b1;
                    end else begin
                        l2a_out_d = 1'b1;
                        evt_inc_s = 1'b1;
                    end
                    cnt_d   = 16'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q >= win_max_s) begin
                    // Timeout still hands the FEEs a reject decision.
                    l2_miss_d = 1'b1;
                    l2r_out_d = 1'b1;
                    cnt_d     = 16'd0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_L2WAIT;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = ST_IDLE;
            end
        endcase

        // Busy covers the capture cycle through the decision-pulse cycle.
        trig_busy_d = busy_in || (state_q != ST_IDLE) || (state_d != ST_IDLE);
        err_inc_s   = l1_early_d || l1_miss_d || l2_miss_d;

        if (cnt_clr) begin
            evt_cnt_d = 24'd0;
        end else if (evt_inc_s) begin
            evt_cnt_d = evt_cnt_q + 24'd1;
        end else begin
            evt_cnt_d = evt_cnt_q;
        end

        if (cnt_clr) begin
            l0_drop_cnt_d = 16'd0;
        end else if (drop_inc_s && (l0_drop_cnt_q != 16'hFFFF)) begin
            l0_drop_cnt_d = l0_drop_cnt_q + 16'd1;
        end else begin
            l0_drop_cnt_d = l0_drop_cnt_q;
        end

        if (cnt_clr) begin
            err_cnt_d = 16'd0;
        end else if (err_inc_s && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State, configuration, output and counter registers.
    always_ff @(posedge ttc_clk40 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 16'd0;
            win_q         <= 32'd0;
            cfg_l1_q      <= L1_TW_INIT;
            cfg_l2_q      <= L2_TW_INIT;
            l1_out_q      <= 1'b0;
            l2a_out_q     <= 1'b0;
            l2r_out_q     <= 1'b0;
            trig_busy_q   <= 1'b0;
            l1_early_q    <= 1'b0;
            l1_miss_q     <= 1'b0;
            l2_miss_q     <= 1'b0;
            evt_cnt_q     <= 24'd0;
            l0_drop_cnt_q <= 16'd0;
            err_cnt_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            win_q         <= win_d;
            cfg_l1_q      <= cfg_l1_d;
            cfg_l2_q      <= cfg_l2_d;
            l1_out_q      <= l1_out_d;
            l2a_out_q     <= l2a_out_d;
            l2r_out_q     <= l2r_out_d;
            trig_busy_q   <= trig_busy_d;
            l1_early_q    <= l1_early_d;
            l1_miss_q     <= l1_miss_d;
            l2_miss_q     <= l2_miss_d;
            evt_cnt_q     <= evt_cnt_d;
            l0_drop_cnt_q <= l0_drop_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign l1_out      = l1_out_q;
    assign l2a_out     = l2a_out_q;
    assign l2r_out     = l2r_out_q;
    assign trig_busy   = trig_busy_q;
    assign l1_early    = l1_early_q;
    assign l1_miss     = l1_miss_q;
    assign l2_miss     = l2_miss_q;
    assign evt_cnt     = evt_cnt_q;
    assign l0_drop_cnt = l0_drop_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_emc_trig_window_seq.sv
// Bench for emc_trig_window_seq: directed trigger scenarios plus random
// traffic, every cycle compared against an elapsed-time reference model.
module tb_emc_trig_window_seq;

    logic        ttc_clk40 = 1'b0;
    logic        reset_n;
    logic [31:0] l1_tw, l2_tw;
    logic        tw_load, l0_trig, l1_in, l2a_in, l2r_in, busy_in, cnt_clr;
    logic        l1_out, l2a_out, l2r_out, trig_busy, l1_early, l1_miss, l2_miss;
    logic [23:0] evt_cnt;
    logic [15:0] l0_drop_cnt, err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: sequence described by phase and the cycle it was anchored at
    int m_cycle, m_phase, m_anchor, m_min, m_max;
    int m_l1min, m_l1max, m_l2min, m_l2max;
    int e_l1, e_l2a, e_l2r, e_busy, e_early, e_l1miss, e_l2miss;
    int e_evt, e_drop, e_err;
    bit got_l1, got_a, got_r;

    emc_trig_window_seq dut (
        .ttc_clk40(ttc_clk40), .reset_n(reset_n), .l1_tw(l1_tw), .l2_tw(l2_tw),
        .tw_load(tw_load), .l0_trig(l0_trig), .l1_in(l1_in), .l2a_in(l2a_in),
        .l2r_in(l2r_in), .busy_in(busy_in), .cnt_clr(cnt_clr), .l1_out(l1_out),
        .l2a_out(l2a_out), .l2r_out(l2r_out), .trig_busy(trig_busy),
        .l1_early(l1_early), .l1_miss(l1_miss), .l2_miss(l2_miss),
        .evt_cnt(evt_cnt), .l0_drop_cnt(l0_drop_cnt), .err_cnt(err_cnt)
    );

    always #5 ttc_clk40 = ~ttc_clk40;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_cycle = 0; m_phase = 0; m_anchor = 0; m_min = 0; m_max = 0;
        m_l1min = 120; m_l1max = 300; m_l2min = 200; m_l2max = 20000;
        e_l1 = 0; e_l2a = 0; e_l2r = 0; e_busy = 0; e_early = 0; e_l1miss = 0; e_l2miss = 0;
        e_evt = 0; e_drop = 0; e_err = 0;
    endtask

    // advance the model by one sampled clock edge using the current inputs
    task automatic model_step();
        int  k;
        bit  was_active, inc_evt, inc_drop, inc_err;
        m_cycle++;
        e_l1 = 0; e_l2a = 0; e_l2r = 0; e_early = 0; e_l1miss = 0; e_l2miss = 0;
        inc_evt = 0; inc_drop = 0; inc_err = 0;
        was_active = (m_phase != 0);
        if (m_phase == 0) begin
            if (l0_trig && busy_in) inc_drop = 1;
            if (l0_trig && !busy_in) begin
                m_phase = 1; m_anchor = m_cycle; m_min = m_l1min; m_max = m_l1max;
            end
            if (tw_load) begin
                m_l1min = int'(l1_tw[15:0]); m_l1max = int'(l1_tw[31:16]);
                m_l2min = int'(l2_tw[15:0]); m_l2max = int'(l2_tw[31:16]);
            end
        end else begin
            k = m_cycle - m_anchor;
            if (l0_trig) inc_drop = 1;
            if (m_phase == 1) begin
                if (l1_in && k >= m_min && k <= m_max) begin
                    e_l1 = 1; m_phase = 2; m_anchor = m_cycle; m_min = m_l2min; m_max = m_l2max;
                end else if (l1_in && k < m_min) begin
                    e_early = 1; inc_err = 1;
                end else if (k >= m_max) begin
                    e_l1miss = 1; inc_err = 1; m_phase = 0;
                end
            end else begin
                if ((l2a_in || l2r_in) && k >= m_min && k <= m_max) begin
                    if (l2r_in) e_l2r = 1;
                    else begin e_l2a = 1; inc_evt = 1; end
                    m_phase = 0;
                end else if (k >= m_max) begin
                    e_l2miss = 1; e_l2r = 1; inc_err = 1; m_phase = 0;
                end
            end
        end
        e_busy = (busy_in || was_active || m_phase != 0) ? 1 : 0;
        if (cnt_clr) begin
            e_evt = 0; e_drop = 0; e_err = 0;
        end else begin
            if (inc_evt) e_evt = (e_evt + 1) % 16777216;
            if (inc_drop && e_drop < 65535) e_drop++;
            if (inc_err && e_err < 65535) e_err++;
        end
    endtask

    task automatic check_all();
        chk("l1_out", 32'(l1_out), e_l1);
        chk("l2a_out", 32'(l2a_out), e_l2a);
        chk("l2r_out", 32'(l2r_out), e_l2r);
        chk("trig_busy", 32'(trig_busy), e_busy);
        chk("l1_early", 32'(l1_early), e_early);
        chk("l1_miss", 32'(l1_miss), e_l1miss);
        chk("l2_miss", 32'(l2_miss), e_l2miss);
        chk("evt_cnt", 32'(evt_cnt), e_evt);
        chk("l0_drop_cnt", 32'(l0_drop_cnt), e_drop);
        chk("err_cnt", 32'(err_cnt), e_err);
    endtask

    task automatic tick();
        @(posedge ttc_clk40);
        model_step();
        @(negedge ttc_clk40);
        check_all();
        l0_trig = 1'b0; l1_in = 1'b0; l2a_in = 1'b0; l2r_in = 1'b0;
        tw_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (m_phase != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(m_phase), 32'd0);
    endtask

    // L0 now, L1 at +l1k, optional L2 at +l2k after the L1, then drain to IDLE
    task automatic run_seq(input int l1k, input int l2k, input bit a, input bit r);
        got_l1 = 0; got_a = 0; got_r = 0;
        l0_trig = 1'b1; tick();
        ticks(l1k - 1);
        l1_in = 1'b1; tick();
        got_l1 = l1_out;
        if (l2k > 0) begin
            ticks(l2k - 1);
            l2a_in = a; l2r_in = r; tick();
            got_a = l2a_out; got_r = l2r_out;
        end
        wait_idle(70000);
    endtask

    task automatic clear_counters();
        cnt_clr = 1'b1; tick();
    endtask

    initial begin
        reset_n = 1'b0; l1_tw = 32'd0; l2_tw = 32'd0; tw_load = 1'b0; l0_trig = 1'b0;
        l1_in = 1'b0; l2a_in = 1'b0; l2r_in = 1'b0; busy_in = 1'b0; cnt_clr = 1'b0;
        m_reset();
        repeat (3) @(negedge ttc_clk40);
        check_all();
        chk("rst_busy", 32'(trig_busy), 32'd0);
        reset_n = 1'b1;
        ticks(3);

        // nominal accept
        run_seq(150, 1000, 1'b1, 1'b0);
        chk("tp1_l1_out", 32'(got_l1), 32'd1);
        chk("tp1_l2a_out", 32'(got_a), 32'd1);
        chk("tp1_evt", 32'(evt_cnt), 32'd1);
        chk("tp1_busy_hold", 32'(trig_busy), 32'd1);
        tick();
        chk("tp1_busy_drop", 32'(trig_busy), 32'd0);

        // early L1 then miss
        clear_counters();
        run_seq(119, 0, 1'b0, 1'b0);
        chk("tp2_no_l1", 32'(got_l1), 32'd0);
        chk("tp2_miss", 32'(l1_miss), 32'd1);
        chk("tp2_err", 32'(err_cnt), 32'd2);
        tick();

        // L1 window edges
        run_seq(120, 300, 1'b1, 1'b0);
        chk("tp3_min_edge", 32'(got_l1), 32'd1);
        run_seq(300, 300, 1'b1, 1'b0);
        chk("tp3_max_edge", 32'(got_l1), 32'd1);
        run_seq(301, 0, 1'b0, 1'b0);
        chk("tp3_past_max", 32'(got_l1), 32'd0);
        tick();

        // L2 timeout gives miss plus reject
        clear_counters();
        run_seq(150, 0, 1'b0, 1'b0);
        chk("tp4_l2_miss", 32'(l2_miss), 32'd1);
        chk("tp4_l2r", 32'(l2r_out), 32'd1);
        chk("tp4_evt", 32'(evt_cnt), 32'd0);
        tick();

        // dropped L0s while busy and while a sequence is open
        clear_counters();
        busy_in = 1'b1;
        for (int i = 0; i < 3; i++) begin l0_trig = 1'b1; tick(); tick(); end
        busy_in = 1'b0; tick();
        l0_trig = 1'b1; tick();
        ticks(9);
        l0_trig = 1'b1; tick();
        wait_idle(1000);
        chk("tp5_drops", 32'(l0_drop_cnt), 32'd4);
        busy_in = 1'b1;
        for (int i = 0; i < 3; i++) begin l0_trig = 1'b1; tick(); end
        l0_trig = 1'b1; cnt_clr = 1'b1; tick();
        chk("tp5_clr", 32'(l0_drop_cnt), 32'd0);
        busy_in = 1'b0; ticks(2);

        // simultaneous accept and reject
        run_seq(150, 300, 1'b1, 1'b1);
        chk("tp6_no_l2a", 32'(got_a), 32'd0);
        chk("tp6_l2r", 32'(got_r), 32'd1);
        tick();

        // asynchronous reset while waiting for L2
        l0_trig = 1'b1; tick();
        ticks(149);
        l1_in = 1'b1; tick();
        ticks(50);
        #3 reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(trig_busy), 32'd0);
        chk("rst_mid_l2r", 32'(l2r_out), 32'd0);
        chk("rst_mid_evt", 32'(evt_cnt), 32'd0);
        m_reset();
        @(negedge ttc_clk40);
        check_all();
        reset_n = 1'b1;
        ticks(400);

        // random traffic over small reloaded windows
        l1_tw = {16'($urandom_range(40)), 16'($urandom_range(35))};
        l2_tw = {16'($urandom_range(40)), 16'($urandom_range(35))};
        tw_load = 1'b1; tick();
        for (int i = 0; i < 5000; i++) begin
            l0_trig = ($urandom_range(19) == 0);
            l1_in   = ($urandom_range(11) == 0);
            l2a_in  = ($urandom_range(14) == 0);
            l2r_in  = ($urandom_range(24) == 0);
            cnt_clr = ($urandom_range(199) == 0);
            if ($urandom_range(29) == 0) busy_in = ~busy_in;
            if ($urandom_range(49) == 0) begin
                l1_tw = {16'($urandom_range(40)), 16'($urandom_range(35))};
                l2_tw = {16'($urandom_range(40)), 16'($urandom_range(35))};
                tw_load = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
